// File: rtl/hwpe_mdc_job_sequencer.sv
// Job sequencer for MDC-based HWPEs: launches N_IN sources, N_OUT sinks and the engine,
// counts sink beats to completion, and flags stalls (watchdog) and sink overruns.
module hwpe_mdc_job_sequencer #(
  parameter int unsigned N_IN  = 2,
  parameter int unsigned N_OUT = 1,
  parameter int unsigned CNT_W = 32,
  parameter int unsigned WD_W  = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clear_i,
  input  logic                   trigger_i,
  input  logic [N_OUT*CNT_W-1:0] cnt_limit_i,
  input  logic [WD_W-1:0]        wd_limit_i,
  input  logic [N_IN-1:0]        src_ready_i,
  input  logic [N_OUT-1:0]       snk_ready_i,
  output logic [N_IN-1:0]        src_req_start_o,
  output logic [N_OUT-1:0]       snk_req_start_o,
  input  logic [N_OUT-1:0]       snk_valid_i,
  input  logic [N_OUT-1:0]       snk_hs_ready_i,
  output logic                   engine_start_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic                   overrun_o,
  output logic [2:0]             state_o
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_COMPUTE = 3'd2,
    ST_DONE    = 3'd3,
    ST_ERROR   = 3'd4
  } state_e;

  state_e                  state_q;
  logic [N_OUT-1:0][CNT_W:0] cnt_q, cnt_d, limit_q, limit_in;
  logic [WD_W-1:0]         wd_q, wd_d, wd_limit_q;
  logic                    overrun_q;
  logic [N_OUT-1:0]        beat, at_limit, full_d;
  logic                    any_beat, all_full, overrun_hit, wd_fire, all_ready, start_fire;

  // Limits carry one extra bit so an all-ones field means 2**CNT_W beats.
  for (genvar gi = 0; gi < N_OUT; gi++) begin : gen_sink
    assign beat[gi]     = snk_valid_i[gi] & snk_hs_ready_i[gi];
    assign limit_in[gi] = {1'b0, cnt_limit_i[gi*CNT_W +: CNT_W]} + (CNT_W+1)'(1);
    assign at_limit[gi] = (cnt_q[gi] == limit_q[gi]);
    assign cnt_d[gi]    = (beat[gi] && !at_limit[gi]) ? cnt_q[gi] + (CNT_W+1)'(1) : cnt_q[gi];
    assign full_d[gi]   = (cnt_d[gi] == limit_q[gi]);
  end

  assign any_beat    = |beat;
  assign all_full    = &full_d;
  assign overrun_hit = |(beat & at_limit);
  assign wd_d        = any_beat ? '0 : wd_q + WD_W'(1);
  assign wd_fire     = (wd_limit_q != '0) && (wd_d == wd_limit_q);
  assign all_ready   = (&src_ready_i) & (&snk_ready_i);
  assign start_fire  = (state_q == ST_START) && all_ready;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      limit_q    <= '0;
      wd_q       <= '0;
      wd_limit_q <= '0;
      overrun_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_ERROR: begin
          if (state_q == ST_IDLE || trigger_i) begin
            cnt_q     <= '0;
            wd_q      <= '0;
            overrun_q <= 1'b0;
          end
          if (trigger_i) begin
            state_q    <= ST_START;
            limit_q    <= limit_in;
            wd_limit_q <= wd_limit_i;
          end
        end
        ST_START: begin
          if (all_ready) state_q <= ST_COMPUTE;
        end
        ST_COMPUTE: begin
          cnt_q <= cnt_d;
          wd_q  <= wd_d;
          if (overrun_hit) overrun_q <= 1'b1;
          // Completion outranks a watchdog expiry in the same cycle.
          if (all_full)     state_q <= ST_DONE;
          else if (wd_fire) state_q <= ST_ERROR;
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign src_req_start_o = {N_IN{start_fire}};
  assign snk_req_start_o = {N_OUT{start_fire}};
  assign engine_start_o  = start_fire;
  assign busy_o          = (state_q != ST_IDLE);
  assign done_o          = (state_q == ST_DONE);
  assign err_o           = (state_q == ST_ERROR);
  assign overrun_o       = overrun_q;
  assign state_o         = state_q;

endmodule
